// File: rtl/board_mem_arbiter_pkg.sv
// Shared definitions for the board memory arbiter: board size defaults,
// cell encoding and the command FSM state type.
package board_mem_arbiter_pkg;

    localparam int BLOCKS_VERTICAL_DEF   = 11;
    localparam int BLOCKS_HORIZONTAL_DEF = 22;
    localparam int CELL_W                = 3;

    typedef logic [CELL_W-1:0] cell_t;

    localparam cell_t EMPTY = '0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TOPCLR,
        WIPE
    } state_t;

endpackage

// File: rtl/board_mem_arbiter_if.sv
// Bus bundle between the board memory and its users (renderer, game logic).
// Names are from the memory's point of view: i_ into it, o_ out of it.
interface board_mem_arbiter_if
    import board_mem_arbiter_pkg::*;
#(
    parameter int BLOCKS_VERTICAL = BLOCKS_VERTICAL_DEF
) ();

    logic                       i_vblank;
    logic [4:0]                 i_vid_v;
    logic [4:0]                 i_vid_h;
    cell_t                      o_vid_type;

    logic                       i_wr_req;
    logic [4:0]                 i_wr_v;
    logic [4:0]                 i_wr_h;
    cell_t                      i_wr_type;
    logic                       o_wr_ack;

    logic                       i_rd_req;
    logic [4:0]                 i_rd_v;
    logic [4:0]                 i_rd_h;
    cell_t                      o_rd_type;
    logic                       o_rd_ack;

    logic                       i_clr_req;
    logic [4:0]                 i_clr_row;
    logic                       i_wipe_req;
    logic                       o_cmd_done;
    logic                       o_busy;
    logic [BLOCKS_VERTICAL-1:0] o_row_full;

    modport slave (
        input  i_vblank, i_vid_v, i_vid_h,
        input  i_wr_req, i_wr_v, i_wr_h, i_wr_type,
        input  i_rd_req, i_rd_v, i_rd_h,
        input  i_clr_req, i_clr_row, i_wipe_req,
        output o_vid_type, o_wr_ack, o_rd_type, o_rd_ack,
        output o_cmd_done, o_busy, o_row_full
    );

    modport master (
        output i_vblank, i_vid_v, i_vid_h,
        output i_wr_req, i_wr_v, i_wr_h, i_wr_type,
        output i_rd_req, i_rd_v, i_rd_h,
        output i_clr_req, i_clr_row, i_wipe_req,
        input  o_vid_type, o_wr_ack, o_rd_type, o_rd_ack,
        input  o_cmd_done, o_busy, o_row_full
    );

endinterface

// File: rtl/board_mem_arbiter_row_full.sv
// Per-row "every cell occupied" detector used for line-clear decisions.
module board_row_full
    import board_mem_arbiter_pkg::*;
#(
    parameter int BLOCKS_VERTICAL   = BLOCKS_VERTICAL_DEF,
    parameter int BLOCKS_HORIZONTAL = BLOCKS_HORIZONTAL_DEF
) (
    input  logic [BLOCKS_HORIZONTAL-1:0][CELL_W-1:0] i_board [BLOCKS_VERTICAL],
    output logic [BLOCKS_VERTICAL-1:0]               o_row_full
);

    // A row is full unless any one of its cells is empty.
    always_comb begin
        o_row_full = '0;
        for (int v = 0; v < BLOCKS_VERTICAL; v++) begin
            o_row_full[v] = 1'b1;
            for (int h = 0; h < BLOCKS_HORIZONTAL; h++) begin
                if (i_board[v][h] == EMPTY) begin
                    o_row_full[v] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// Board memory with a free-running renderer port, a single-cell write port,
// a read port, and multi-cycle row-clear / whole-board wipe commands.
// A request whose ack (or cmd_done) is showing in the current cycle is not
// re-accepted, because the requester is still holding it during that cycle.
module board_mem_arbiter
    import board_mem_arbiter_pkg::*;
#(
    parameter int BLOCKS_VERTICAL   = BLOCKS_VERTICAL_DEF,
    parameter int BLOCKS_HORIZONTAL = BLOCKS_HORIZONTAL_DEF
) (
    input  logic                clk_25_175,
    input  logic                reset,
    board_mem_arbiter_if.slave  bus
);

    localparam int VW = (BLOCKS_VERTICAL > 1)   ? $clog2(BLOCKS_VERTICAL)   : 1;
    localparam int HW = (BLOCKS_HORIZONTAL > 1) ? $clog2(BLOCKS_HORIZONTAL) : 1;
    localparam logic [4:0]    V_LIM    = 5'(BLOCKS_VERTICAL);
    localparam logic [4:0]    H_LIM    = 5'(BLOCKS_HORIZONTAL);
    localparam logic [VW-1:0] LAST_ROW = VW'(BLOCKS_VERTICAL - 1);

    typedef logic [BLOCKS_HORIZONTAL-1:0][CELL_W-1:0] row_t;

    row_t                       r_board [BLOCKS_VERTICAL];
    state_t                     r_state;
    state_t                     w_state_next;
    logic [VW-1:0]              r_ptr;
    logic [VW-1:0]              w_ptr_next;
    logic [VW-1:0]              w_ptr_m1;
    logic                       w_done_next;
    logic                       r_wr_ack;
    logic                       r_rd_ack;
    logic                       r_cmd_done;
    cell_t                      r_rd_type;
    logic [BLOCKS_VERTICAL-1:0] r_row_full;
    logic [BLOCKS_VERTICAL-1:0] w_row_full;
    logic                       w_idle;
    logic                       w_wipe_go;
    logic                       w_clr_go;
    logic                       w_wr_go;
    logic                       w_rd_go;
    logic                       w_wr_ok;
    logic                       w_rd_ok;
    logic                       w_vid_ok;
    logic                       w_clr_ok;
    cell_t                      w_rd_cell;

    assign w_idle    = (r_state == IDLE);
    assign w_wipe_go = bus.i_wipe_req && bus.i_vblank && w_idle && !r_cmd_done;
    assign w_clr_go  = bus.i_clr_req && !bus.i_wipe_req && bus.i_vblank && w_idle && !r_cmd_done;
    assign w_wr_go   = bus.i_wr_req && !bus.i_wipe_req && !bus.i_clr_req && bus.i_vblank
                       && w_idle && !r_wr_ack;
    assign w_rd_go   = bus.i_rd_req && w_idle && !r_rd_ack && !w_wipe_go && !w_clr_go && !w_wr_go;

    assign w_wr_ok   = (bus.i_wr_v < V_LIM) && (bus.i_wr_h < H_LIM);
    assign w_rd_ok   = (bus.i_rd_v < V_LIM) && (bus.i_rd_h < H_LIM);
    assign w_vid_ok  = (bus.i_vid_v < V_LIM) && (bus.i_vid_h < H_LIM);
    assign w_clr_ok  = (bus.i_clr_row < V_LIM);
    assign w_ptr_m1  = r_ptr - 1'b1;

    assign w_rd_cell = w_rd_ok ? r_board[bus.i_rd_v[VW-1:0]][bus.i_rd_h[HW-1:0]] : EMPTY;

    assign bus.o_vid_type = w_vid_ok ? r_board[bus.i_vid_v[VW-1:0]][bus.i_vid_h[HW-1:0]] : EMPTY;
    assign bus.o_wr_ack   = r_wr_ack;
    assign bus.o_rd_ack   = r_rd_ack;
    assign bus.o_rd_type  = r_rd_type;
    assign bus.o_cmd_done = r_cmd_done;
    assign bus.o_row_full = r_row_full;

    board_row_full #(
        .BLOCKS_VERTICAL   (BLOCKS_VERTICAL),
        .BLOCKS_HORIZONTAL (BLOCKS_HORIZONTAL)
    ) u_row_full (
        .i_board    (r_board),
        .o_row_full (w_row_full)
    );

    // FSM state and row pointer register.
    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Command sequencing: shift rows down toward the cleared row, then blank row 0.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wipe_go) begin
                    w_state_next = WIPE;
                    w_ptr_next   = '0;
                end else if (w_clr_go) begin
                    if (!w_clr_ok) begin
                        w_done_next = 1'b1;
                    end else if (bus.i_clr_row == 5'd0) begin
                        w_state_next = TOPCLR;
                        w_ptr_next   = '0;
                    end else begin
                        w_state_next = SHIFT;
                        w_ptr_next   = bus.i_clr_row[VW-1:0];
                    end
                end
            end
            SHIFT: begin
                w_ptr_next = w_ptr_m1;
                if (r_ptr == VW'(1)) begin
                    w_state_next = TOPCLR;
                end
            end
            TOPCLR: begin
                w_state_next = IDLE;
                w_ptr_next   = '0;
                w_done_next  = 1'b1;
            end
            WIPE: begin
                if (r_ptr == LAST_ROW) begin
                    w_state_next = IDLE;
                    w_ptr_next   = '0;
                    w_done_next  = 1'b1;
                end else begin
                    w_ptr_next = r_ptr + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_ptr_next   = '0;
            end
        endcase
    end

    // Busy reflects any non-idle FSM state.
    always_comb begin
        bus.o_busy = !w_idle;
    end

    // Board storage: command row moves take the port; writes land at acceptance.
    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            for (int v = 0; v < BLOCKS_VERTICAL; v++) begin
                r_board[v] <= '0;
            end
        end else begin
            case (r_state)
                SHIFT:   r_board[r_ptr] <= r_board[w_ptr_m1];
                TOPCLR:  r_board[0] <= '0;
                WIPE:    r_board[r_ptr] <= '0;
                default: begin
                    if (w_wr_go && w_wr_ok) begin
                        r_board[bus.i_wr_v[VW-1:0]][bus.i_wr_h[HW-1:0]] <= bus.i_wr_type;
                    end
                end
            endcase
        end
    end

    // Handshake pulses, read data and the lagging row-full mask.
    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            r_wr_ack   <= 1'b0;
            r_rd_ack   <= 1'b0;
            r_cmd_done <= 1'b0;
            r_rd_type  <= EMPTY;
            r_row_full <= '0;
        end else begin
            r_wr_ack   <= w_wr_go;
            r_rd_ack   <= w_rd_go;
            r_cmd_done <= w_done_next;
            r_row_full <= w_row_full;
            if (w_rd_go) begin
                r_rd_type <= w_rd_cell;
            end
        end
    end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Self-checking bench for board_mem_arbiter: a reference board model plus a
// read scoreboard (expected rd_type queued at request, compared at rd_ack).
module tb_board_mem_arbiter;
    import board_mem_arbiter_pkg::*;

    localparam int BV  = 11;
    localparam int BH  = 22;
    localparam int TMO = 40;

    logic clk_25_175 = 1'b0;
    logic reset      = 1'b0;

    board_mem_arbiter_if #(.BLOCKS_VERTICAL(BV)) bus ();

    board_mem_arbiter #(
        .BLOCKS_VERTICAL   (BV),
        .BLOCKS_HORIZONTAL (BH)
    ) dut (
        .clk_25_175 (clk_25_175),
        .reset      (reset),
        .bus        (bus)
    );

    always #20 clk_25_175 = ~clk_25_175;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] model [BV][BH];
    logic [2:0] exp_q [$];
    logic [2:0] exp_v;

    // Scoreboard: every rd_ack consumes the oldest queued expectation.
    always @(negedge clk_25_175) begin
        if (reset && bus.o_rd_ack === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL rd_unexpected got rd_ack=1 want no ack (queue empty)");
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.o_rd_type !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL rd_type got %0d want %0d", bus.o_rd_type, exp_v);
                end
            end
        end
    end

    function automatic logic [BV-1:0] model_row_full();
        logic [BV-1:0] r;
        r = '0;
        for (int v = 0; v < BV; v++) begin
            r[v] = 1'b1;
            for (int h = 0; h < BH; h++) begin
                if (model[v][h] == 3'd0) r[v] = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic do_write(input int v, input int h, input logic [2:0] t, output int lat);
        bus.i_wr_v    = 5'(v);
        bus.i_wr_h    = 5'(h);
        bus.i_wr_type = t;
        bus.i_wr_req  = 1'b1;
        lat = -1;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk_25_175);
            if (bus.o_wr_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.i_wr_req = 1'b0;
        checks++;
        if (lat < 0) begin
            errors++;
            $display("[TB] FAIL wr_timeout got no wr_ack want ack within %0d cycles", TMO);
        end else if (v < BV && h < BH) begin
            model[v][h] = t;
        end
    endtask

    task automatic do_read(input int v, input int h, output int lat);
        exp_q.push_back((v < BV && h < BH) ? model[v][h] : 3'd0);
        bus.i_rd_v   = 5'(v);
        bus.i_rd_h   = 5'(h);
        bus.i_rd_req = 1'b1;
        lat = -1;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk_25_175);
            if (bus.o_rd_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.i_rd_req = 1'b0;
        checks++;
        if (lat < 0) begin
            errors++;
            $display("[TB] FAIL rd_timeout got no rd_ack want ack within %0d cycles", TMO);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk_25_175);
        bus.i_vid_v = 5'd3;
        bus.i_vid_h = 5'd5;
        #1;
        checks++; if (bus.o_busy !== 1'b0)     begin errors++; $display("[TB] FAIL rst_busy got %0b want 0", bus.o_busy); end
        checks++; if (bus.o_wr_ack !== 1'b0)   begin errors++; $display("[TB] FAIL rst_wr_ack got %0b want 0", bus.o_wr_ack); end
        checks++; if (bus.o_rd_ack !== 1'b0)   begin errors++; $display("[TB] FAIL rst_rd_ack got %0b want 0", bus.o_rd_ack); end
        checks++; if (bus.o_cmd_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_cmd_done got %0b want 0", bus.o_cmd_done); end
        checks++; if (bus.o_rd_type !== 3'd0)  begin errors++; $display("[TB] FAIL rst_rd_type got %0d want 0", bus.o_rd_type); end
        checks++; if (bus.o_row_full !== '0)   begin errors++; $display("[TB] FAIL rst_row_full got %h want 0", bus.o_row_full); end
        checks++; if (bus.o_vid_type !== 3'd0) begin errors++; $display("[TB] FAIL rst_vid got %0d want 0", bus.o_vid_type); end
        for (int v = 0; v < BV; v++) for (int h = 0; h < BH; h++) model[v][h] = 3'd0;
        reset = 1'b1;
        @(negedge clk_25_175);
    endtask

    task automatic test_write_read();
        int lat;
        bus.i_vblank = 1'b1;
        do_write(3, 5, 3'd4, lat);
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL wr_latency got %0d want 1", lat); end
        do_read(3, 5, lat);
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL rd_latency got %0d want 1", lat); end
        bus.i_vid_v = 5'd3;  bus.i_vid_h = 5'd5;  #1;
        checks++; if (bus.o_vid_type !== 3'd4) begin errors++; $display("[TB] FAIL vid_3_5 got %0d want 4", bus.o_vid_type); end
        bus.i_vid_v = 5'd12; bus.i_vid_h = 5'd0;  #1;
        checks++; if (bus.o_vid_type !== 3'd0) begin errors++; $display("[TB] FAIL vid_oor_v got %0d want 0", bus.o_vid_type); end
        bus.i_vid_v = 5'd0;  bus.i_vid_h = 5'd22; #1;
        checks++; if (bus.o_vid_type !== 3'd0) begin errors++; $display("[TB] FAIL vid_oor_h got %0d want 0", bus.o_vid_type); end
        @(negedge clk_25_175);
    endtask

    task automatic test_vblank_gate();
        int nwr;
        int nrd;
        int lat;
        bus.i_vblank  = 1'b0;
        bus.i_wr_v    = 5'd2;
        bus.i_wr_h    = 5'd2;
        bus.i_wr_type = 3'd6;
        bus.i_wr_req  = 1'b1;
        bus.i_rd_v    = 5'd2;
        bus.i_rd_h    = 5'd2;
        bus.i_rd_req  = 1'b1;
        exp_q.push_back(3'd0);
        nwr = 0;
        nrd = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_25_175);
            if (bus.o_wr_ack === 1'b1) nwr++;
            if (bus.o_rd_ack === 1'b1) begin
                nrd++;
                bus.i_rd_req = 1'b0;
            end
        end
        checks++; if (nwr != 0) begin errors++; $display("[TB] FAIL vblank_wr_blocked got %0d acks want 0", nwr); end
        checks++; if (nrd != 1) begin errors++; $display("[TB] FAIL vblank_rd_ok got %0d acks want 1", nrd); end
        bus.i_vblank = 1'b1;
        lat = -1;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk_25_175);
            if (bus.o_wr_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.i_wr_req = 1'b0;
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL vblank_wr_release got %0d want 1", lat); end
        if (lat > 0) model[2][2] = 3'd6;
        do_read(2, 2, lat);
    endtask

    task automatic test_clear_row();
        int            lat;
        int            nb;
        int            done_at;
        logic [BV-1:0] rf_exp;
        bus.i_vblank = 1'b1;
        do_write(0, 3, 3'd5, lat);
        for (int h = 0; h < BH; h++) do_write(10, h, 3'(h % 7 + 1), lat);
        for (int h = 0; h < BH; h++) do_write(9, h, 3'd2, lat);
        rf_exp = '0;
        rf_exp[10] = 1'b1;
        checks++; if (bus.o_row_full !== rf_exp) begin errors++; $display("[TB] FAIL row_full_lag got %h want %h", bus.o_row_full, rf_exp); end
        @(negedge clk_25_175);
        rf_exp = model_row_full();
        checks++; if (bus.o_row_full !== rf_exp || rf_exp[10] !== 1'b1) begin errors++; $display("[TB] FAIL row_full_pre got %h want %h", bus.o_row_full, rf_exp); end
        bus.i_clr_row = 5'd10;
        bus.i_clr_req = 1'b1;
        nb = 0;
        done_at = -1;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk_25_175);
            if (bus.o_busy === 1'b1) begin
                nb++;
                bus.i_vblank = 1'b0;
            end
            if (bus.o_cmd_done === 1'b1) begin
                done_at = i;
                bus.i_clr_req = 1'b0;
                break;
            end
        end
        bus.i_clr_req = 1'b0;
        bus.i_vblank  = 1'b1;
        checks++; if (nb != 11)      begin errors++; $display("[TB] FAIL clr_busy_len got %0d want 11", nb); end
        checks++; if (done_at != 12) begin errors++; $display("[TB] FAIL clr_done_at got %0d want 12", done_at); end
        for (int v = BV - 1; v > 0; v--) for (int h = 0; h < BH; h++) model[v][h] = model[v-1][h];
        for (int h = 0; h < BH; h++) model[0][h] = 3'd0;
        for (int v = 0; v < BV; v++) begin
            for (int h = 0; h < BH; h++) begin
                bus.i_vid_v = 5'(v); bus.i_vid_h = 5'(h); #1;
                checks++;
                if (bus.o_vid_type !== model[v][h]) begin errors++; $display("[TB] FAIL clr_cell(%0d,%0d) got %0d want %0d", v, h, bus.o_vid_type, model[v][h]); end
            end
        end
        @(negedge clk_25_175);
        rf_exp = model_row_full();
        checks++; if (bus.o_row_full !== rf_exp) begin errors++; $display("[TB] FAIL row_full_post got %h want %h", bus.o_row_full, rf_exp); end
    endtask

    task automatic test_clear_top();
        int lat;
        int nb;
        int done_at;
        do_write(0, 7, 3'd5, lat);
        bus.i_clr_row = 5'd0;
        bus.i_clr_req = 1'b1;
        nb = 0;
        done_at = -1;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk_25_175);
            if (bus.o_busy === 1'b1) nb++;
            if (bus.o_cmd_done === 1'b1) begin
                done_at = i;
                break;
            end
        end
        bus.i_clr_req = 1'b0;
        checks++; if (nb != 1)      begin errors++; $display("[TB] FAIL top_busy_len got %0d want 1", nb); end
        checks++; if (done_at != 2) begin errors++; $display("[TB] FAIL top_done_at got %0d want 2", done_at); end
        model[0][7] = 3'd0;
        bus.i_vid_v = 5'd0; bus.i_vid_h = 5'd7; #1;
        checks++; if (bus.o_vid_type !== 3'd0) begin errors++; $display("[TB] FAIL top_cleared got %0d want 0", bus.o_vid_type); end
        bus.i_vid_v = 5'd1; bus.i_vid_h = 5'd3; #1;
        checks++; if (bus.o_vid_type !== model[1][3]) begin errors++; $display("[TB] FAIL top_row1_kept got %0d want %0d", bus.o_vid_type, model[1][3]); end
        @(negedge clk_25_175);
    endtask

    task automatic test_wipe_priority();
        int nb;
        int done_at;
        int wr_at;
        bus.i_vblank   = 1'b1;
        bus.i_wr_v     = 5'd1;
        bus.i_wr_h     = 5'd1;
        bus.i_wr_type  = 3'd3;
        bus.i_wr_req   = 1'b1;
        bus.i_wipe_req = 1'b1;
        nb = 0;
        done_at = -1;
        wr_at = -1;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk_25_175);
            if (bus.o_busy === 1'b1) nb++;
            if (bus.o_cmd_done === 1'b1) begin
                done_at = i;
                bus.i_wipe_req = 1'b0;
            end
            if (bus.o_wr_ack === 1'b1) begin
                wr_at = i;
                break;
            end
        end
        bus.i_wr_req   = 1'b0;
        bus.i_wipe_req = 1'b0;
        checks++; if (nb != 11)      begin errors++; $display("[TB] FAIL wipe_busy_len got %0d want 11", nb); end
        checks++; if (done_at != 12) begin errors++; $display("[TB] FAIL wipe_done_at got %0d want 12", done_at); end
        checks++; if (wr_at != 13)   begin errors++; $display("[TB] FAIL wipe_wr_after got %0d want 13", wr_at); end
        for (int v = 0; v < BV; v++) for (int h = 0; h < BH; h++) model[v][h] = 3'd0;
        if (wr_at > 0) model[1][1] = 3'd3;
        for (int v = 0; v < BV; v++) begin
            for (int h = 0; h < BH; h++) begin
                bus.i_vid_v = 5'(v); bus.i_vid_h = 5'(h); #1;
                checks++;
                if (bus.o_vid_type !== model[v][h]) begin errors++; $display("[TB] FAIL wipe_cell(%0d,%0d) got %0d want %0d", v, h, bus.o_vid_type, model[v][h]); end
            end
        end
        @(negedge clk_25_175);
    endtask

    task automatic test_out_of_range();
        int lat;
        int nb;
        int done_at;
        bus.i_clr_row = 5'd15;
        bus.i_clr_req = 1'b1;
        nb = 0;
        done_at = -1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_25_175);
            if (bus.o_busy === 1'b1) nb++;
            if (bus.o_cmd_done === 1'b1) begin
                if (done_at < 0) done_at = i;
                bus.i_clr_req = 1'b0;
            end
        end
        bus.i_clr_req = 1'b0;
        checks++; if (done_at != 1) begin errors++; $display("[TB] FAIL oor_clr_done got %0d want 1", done_at); end
        checks++; if (nb != 0)      begin errors++; $display("[TB] FAIL oor_clr_busy got %0d want 0", nb); end
        do_write(12, 0, 3'd7, lat);
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL oor_wr_ack got %0d want 1", lat); end
        do_write(0, 22, 3'd5, lat);
        for (int v = 0; v < BV; v++) begin
            for (int h = 0; h < BH; h++) begin
                bus.i_vid_v = 5'(v); bus.i_vid_h = 5'(h); #1;
                checks++;
                if (bus.o_vid_type !== model[v][h]) begin errors++; $display("[TB] FAIL oor_cell(%0d,%0d) got %0d want %0d", v, h, bus.o_vid_type, model[v][h]); end
            end
        end
        @(negedge clk_25_175);
        do_read(12, 0, lat);
        do_read(4, 30, lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        int nb;
        int nd;
        bus.i_vblank = 1'b1;
        do_write(5, 5, 3'd2, lat);
        do_read(5, 5, lat);
        bus.i_clr_row = 5'd6;
        bus.i_clr_req = 1'b1;
        nb = 0;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk_25_175);
            if (bus.o_busy === 1'b1) nb++;
            if (nb == 3) break;
        end
        checks++; if (nb != 3) begin errors++; $display("[TB] FAIL mid_reach_shift3 got %0d want 3", nb); end
        reset = 1'b0;
        bus.i_clr_req = 1'b0;
        @(negedge clk_25_175);
        bus.i_vid_v = 5'd5; bus.i_vid_h = 5'd5; #1;
        checks++; if (bus.o_busy !== 1'b0)     begin errors++; $display("[TB] FAIL mid_busy got %0b want 0", bus.o_busy); end
        checks++; if (bus.o_cmd_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_cmd_done got %0b want 0", bus.o_cmd_done); end
        checks++; if (bus.o_rd_type !== 3'd0)  begin errors++; $display("[TB] FAIL mid_rd_type got %0d want 0", bus.o_rd_type); end
        checks++; if (bus.o_vid_type !== 3'd0) begin errors++; $display("[TB] FAIL mid_cell_5_5 got %0d want 0", bus.o_vid_type); end
        reset = 1'b1;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_25_175);
            if (bus.o_cmd_done === 1'b1) nd++;
            if (bus.o_busy === 1'b1) nb++;
        end
        checks++; if (nd != 0) begin errors++; $display("[TB] FAIL mid_no_done got %0d want 0", nd); end
        checks++; if (nb != 0) begin errors++; $display("[TB] FAIL mid_no_busy got %0d want 0", nb); end
        checks++; if (bus.o_row_full !== '0) begin errors++; $display("[TB] FAIL mid_row_full got %h want 0", bus.o_row_full); end
        for (int v = 0; v < BV; v++) for (int h = 0; h < BH; h++) model[v][h] = 3'd0;
        for (int v = 0; v < BV; v++) begin
            for (int h = 0; h < BH; h++) begin
                bus.i_vid_v = 5'(v); bus.i_vid_h = 5'(h); #1;
                checks++;
                if (bus.o_vid_type !== 3'd0) begin errors++; $display("[TB] FAIL mid_cell(%0d,%0d) got %0d want 0", v, h, bus.o_vid_type); end
            end
        end
        @(negedge clk_25_175);
    endtask

    initial begin
        bus.i_vblank   = 1'b0;
        bus.i_vid_v    = '0;
        bus.i_vid_h    = '0;
        bus.i_wr_req   = 1'b0;
        bus.i_wr_v     = '0;
        bus.i_wr_h     = '0;
        bus.i_wr_type  = '0;
        bus.i_rd_req   = 1'b0;
        bus.i_rd_v     = '0;
        bus.i_rd_h     = '0;
        bus.i_clr_req  = 1'b0;
        bus.i_clr_row  = '0;
        bus.i_wipe_req = 1'b0;

        test_reset();
        test_write_read();
        test_vblank_gate();
        test_clear_row();
        test_clear_top();
        test_wipe_priority();
        test_out_of_range();
        test_reset_mid();

        repeat (2) @(negedge clk_25_175);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rd_pending got %0d queued want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
